// File: rtl/fpnew_pkg.sv
// Shared FPU types: rounding mode encodings and a legality helper.
// Imported by the round arbiter and the rounding datapath.
package fpnew_pkg;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    ROD = 3'b101,
    DYN = 3'b111
  } roundmode_e;

  function automatic logic is_legal_rm(
    input logic [2:0] rm
  );
    return (rm != 3'b110) && (rm != 3'b111);
  endfunction

endpackage

// File: rtl/fpnew_rounding.sv
// Rounds a pre-rounded magnitude using round/sticky bits and a mode.
// Ports: abs/sign/rs/mode/effsub in; rounded abs, sign, exact-zero out.
module fpnew_rounding
  import fpnew_pkg::*;
#(
  parameter int AbsWidth = 26
) (
  input  logic [AbsWidth-1:0] abs_value_i,
  input  logic                sign_i,
  input  logic [1:0]          round_sticky_bits_i,
  input  logic [2:0]          rnd_mode_i,
  input  logic                effective_subtraction_i,
  output logic [AbsWidth-1:0] abs_rounded_o,
  output logic                sign_o,
  output logic                exact_zero_o
);

  logic       round_up;
  logic [1:0] rs;

  assign rs = round_sticky_bits_i;

  always_comb begin
    round_up = 1'b0;
    unique case (roundmode_e'(rnd_mode_i))
      RNE: round_up = rs[1] & (rs[0] | abs_value_i[0]);
      RTZ: round_up = 1'b0;
      RDN: round_up = (|rs) & sign_i;
      RUP: round_up = (|rs) & ~sign_i;
      RMM: round_up = rs[1];
      ROD: round_up = (|rs) & ~abs_value_i[0];
      default: round_up = 1'b0;
    endcase
  end

  // Carry-out is dropped; the exponent path handles it.
  assign abs_rounded_o = abs_value_i + AbsWidth'(round_up);

  assign exact_zero_o = (abs_value_i == '0) && (rs == 2'b00);

  // An exact zero from subtraction is -0 only when rounding down.
  assign sign_o = (exact_zero_o && effective_subtraction_i)
                ? (rnd_mode_i == RDN)
                : sign_i;

endmodule

// File: rtl/fpnew_round_arbiter.sv
// Round-robin share of one rounding datapath among NumReq FP units.
// Ports: per-requester valid/ready+operands in; registered result out.
module fpnew_round_arbiter
  import fpnew_pkg::*;
#(
  parameter int NumReq   = 3,
  parameter int AbsWidth = 26,
  parameter int TagWidth = 4,
  localparam int IdW = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic [2:0]                   frm_i,
  input  logic [NumReq-1:0]            in_valid_i,
  output logic [NumReq-1:0]            in_ready_o,
  input  logic [NumReq*AbsWidth-1:0]   in_abs_i,
  input  logic [NumReq-1:0]            in_sign_i,
  input  logic [NumReq*2-1:0]          in_rs_i,
  input  logic [NumReq*3-1:0]          in_rm_i,
  input  logic [NumReq-1:0]            in_effsub_i,
  input  logic [NumReq*TagWidth-1:0]   in_tag_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [AbsWidth-1:0]          out_abs_o,
  output logic                         out_sign_o,
  output logic                         out_exact_zero_o,
  output logic                         out_inexact_o,
  output logic                         out_illegal_rm_o,
  output logic [TagWidth-1:0]          out_tag_o,
  output logic [IdW-1:0]               out_id_o
);

  logic [IdW-1:0]      ptr_q, ptr_d, grant;
  logic                any_valid, accept, found;
  logic [2*NumReq-1:0] dbl;
  logic [NumReq-1:0]   rot;
  int                  off, sum;

  // Rotate valids so bit 0 is the pointer slot, then find first set.
  always_comb begin
    any_valid = |in_valid_i;
    dbl       = {in_valid_i, in_valid_i};
    rot       = NumReq'(dbl >> ptr_q);
    found     = 1'b0;
    off       = 0;
    for (int k = 0; k < NumReq; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        off   = k;
      end
    end
    sum = int'(ptr_q) + off;
    if (sum >= NumReq) sum = sum - NumReq;
    grant = IdW'(sum);
    ptr_d = (int'(grant) == NumReq - 1) ? '0 : grant + 1'b1;
  end

  assign accept = any_valid & ~flush_i
                & (~out_valid_o | out_ready_i);

  assign in_ready_o = accept ? (NumReq'(1) << grant) : '0;

  logic [AbsWidth-1:0] g_abs;
  logic                g_sign, g_effsub;
  logic [1:0]          g_rs;
  logic [2:0]          g_rm, rm_res, rm_eff;
  logic [TagWidth-1:0] g_tag;
  logic                illegal;

  always_comb begin
    g_abs    = '0;
    g_sign   = 1'b0;
    g_effsub = 1'b0;
    g_rs     = '0;
    g_rm     = '0;
    g_tag    = '0;
    for (int k = 0; k < NumReq; k++) begin
      if (grant == IdW'(k)) begin
        g_abs    = in_abs_i[k*AbsWidth +: AbsWidth];
        g_sign   = in_sign_i[k];
        g_effsub = in_effsub_i[k];
        g_rs     = in_rs_i[k*2 +: 2];
        g_rm     = in_rm_i[k*3 +: 3];
        g_tag    = in_tag_i[k*TagWidth +: TagWidth];
      end
    end
  end

  assign rm_res  = (g_rm == DYN) ? frm_i : g_rm;
  assign illegal = ~is_legal_rm(rm_res);
  assign rm_eff  = illegal ? RNE : rm_res;

  logic [AbsWidth-1:0] r_abs;
  logic                r_sign, r_zero;

  fpnew_rounding #(
    .AbsWidth (AbsWidth)
  ) i_rounding (
    .abs_value_i             (g_abs),
    .sign_i                  (g_sign),
    .round_sticky_bits_i     (g_rs),
    .rnd_mode_i              (rm_eff),
    .effective_subtraction_i (g_effsub),
    .abs_rounded_o           (r_abs),
    .sign_o                  (r_sign),
    .exact_zero_o            (r_zero)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q            <= '0;
      out_valid_o      <= 1'b0;
      out_abs_o        <= '0;
      out_sign_o       <= 1'b0;
      out_exact_zero_o <= 1'b0;
      out_inexact_o    <= 1'b0;
      out_illegal_rm_o <= 1'b0;
      out_tag_o        <= '0;
      out_id_o         <= '0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
    end else if (accept) begin
      ptr_q            <= ptr_d;
      out_valid_o      <= 1'b1;
      out_abs_o        <= r_abs;
      out_sign_o       <= r_sign;
      out_exact_zero_o <= r_zero;
      out_inexact_o    <= |g_rs;
      out_illegal_rm_o <= illegal;
      out_tag_o        <= g_tag;
      out_id_o         <= grant;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fpnew_round_arbiter.sv
// Scoreboard bench for fpnew_round_arbiter (NumReq=3, AbsWidth=8).
// Driver pushes expected results; a negedge monitor pops and compares.
module tb_fpnew_round_arbiter;

  localparam int N  = 3;
  localparam int AW = 8;
  localparam int TW = 4;
  localparam int IW = 2;

  logic            clk_i = 1'b0;
  logic            rst_i, flush_i;
  logic [2:0]      frm_i;
  logic [N-1:0]    in_valid_i, in_ready_o;
  logic [N*AW-1:0] in_abs_i;
  logic [N-1:0]    in_sign_i, in_effsub_i;
  logic [N*2-1:0]  in_rs_i;
  logic [N*3-1:0]  in_rm_i;
  logic [N*TW-1:0] in_tag_i;
  logic            out_valid_o, out_ready_i;
  logic [AW-1:0]   out_abs_o;
  logic            out_sign_o, out_exact_zero_o;
  logic            out_inexact_o, out_illegal_rm_o;
  logic [TW-1:0]   out_tag_o;
  logic [IW-1:0]   out_id_o;

  fpnew_round_arbiter #(
    .NumReq   (N),
    .AbsWidth (AW),
    .TagWidth (TW)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .flush_i          (flush_i),
    .frm_i            (frm_i),
    .in_valid_i       (in_valid_i),
    .in_ready_o       (in_ready_o),
    .in_abs_i         (in_abs_i),
    .in_sign_i        (in_sign_i),
    .in_rs_i          (in_rs_i),
    .in_rm_i          (in_rm_i),
    .in_effsub_i      (in_effsub_i),
    .in_tag_i         (in_tag_i),
    .out_valid_o      (out_valid_o),
    .out_ready_i      (out_ready_i),
    .out_abs_o        (out_abs_o),
    .out_sign_o       (out_sign_o),
    .out_exact_zero_o (out_exact_zero_o),
    .out_inexact_o    (out_inexact_o),
    .out_illegal_rm_o (out_illegal_rm_o),
    .out_tag_o        (out_tag_o),
    .out_id_o         (out_id_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [AW-1:0] abs;
    logic          sign;
    logic          ez;
    logic          inx;
    logic          ill;
    logic [TW-1:0] tag;
    logic [IW-1:0] id;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    exp_t e;
    if (out_valid_o === 1'b1 && (flush_i || rst_i)) begin
      if (q.size() > 0) e = q.pop_front();
    end else if (out_valid_o === 1'b1 && out_ready_i) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out: got id %0d expected none",
                 out_id_o);
      end else begin
        e = q.pop_front();
        check("abs",  32'(out_abs_o), 32'(e.abs));
        check("sign", 32'(out_sign_o), 32'(e.sign));
        check("ez",   32'(out_exact_zero_o), 32'(e.ez));
        check("inx",  32'(out_inexact_o), 32'(e.inx));
        check("ill",  32'(out_illegal_rm_o), 32'(e.ill));
        check("tag",  32'(out_tag_o), 32'(e.tag));
        check("id",   32'(out_id_o), 32'(e.id));
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(
    input int         r,
    input logic [7:0] a,
    input logic       s,
    input logic [1:0] rs,
    input logic [2:0] rm,
    input logic       es,
    input logic [3:0] tg
  );
    in_valid_i[r]       = 1'b1;
    in_abs_i[r*AW +: AW] = a;
    in_sign_i[r]        = s;
    in_rs_i[r*2 +: 2]   = rs;
    in_rm_i[r*3 +: 3]   = rm;
    in_effsub_i[r]      = es;
    in_tag_i[r*TW +: TW] = tg;
  endtask

  task automatic push(
    input int         r,
    input logic [7:0] ea,
    input logic       esg,
    input logic       eez,
    input logic       einx,
    input logic       eill,
    input logic [3:0] tg
  );
    exp_t e;
    e.abs  = ea;
    e.sign = esg;
    e.ez   = eez;
    e.inx  = einx;
    e.ill  = eill;
    e.tag  = tg;
    e.id   = IW'(r);
    q.push_back(e);
  endtask

  task automatic send(
    input int         r,
    input logic [7:0] a,
    input logic       s,
    input logic [1:0] rs,
    input logic [2:0] rm,
    input logic       es,
    input logic [3:0] tg,
    input logic [7:0] ea,
    input logic       esg,
    input logic       eez,
    input logic       eill,
    input logic       rdy
  );
    in_valid_i  = '0;
    out_ready_i = rdy;
    set_req(r, a, s, rs, rm, es, tg);
    #1;
    check("ready", 32'(in_ready_o), 32'(1 << r));
    push(r, ea, esg, eez, |rs, eill, tg);
    step();
    in_valid_i = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_i       = 1'b1;
    flush_i     = 1'b0;
    frm_i       = 3'b000;
    in_valid_i  = '0;
    in_abs_i    = '0;
    in_sign_i   = '0;
    in_rs_i     = '0;
    in_rm_i     = '0;
    in_effsub_i = '0;
    in_tag_i    = '0;
    out_ready_i = 1'b1;
    step();
    step();
    check("rst_valid", 32'(out_valid_o), 0);
    check("rst_abs",   32'(out_abs_o), 0);
    check("rst_tag",   32'(out_tag_o), 0);
    check("rst_id",    32'(out_id_o), 0);
    check("rst_flags", 32'({out_sign_o, out_exact_zero_o,
                            out_inexact_o, out_illegal_rm_o}), 0);
    rst_i = 1'b0;
    step();

    // RNE ties and other modes on requester 0
    send(0, 8'h05, 0, 2'b10, 3'b000, 0, 4'h1, 8'h06, 0, 0, 0, 1);
    send(0, 8'h04, 0, 2'b10, 3'b000, 0, 4'h2, 8'h04, 0, 0, 0, 1);
    send(0, 8'h03, 0, 2'b11, 3'b000, 0, 4'h3, 8'h04, 0, 0, 0, 1);
    send(0, 8'h07, 0, 2'b10, 3'b100, 0, 4'h4, 8'h08, 0, 0, 0, 1);
    send(0, 8'h08, 0, 2'b01, 3'b101, 0, 4'h5, 8'h09, 0, 0, 0, 1);
    send(0, 8'hFF, 0, 2'b11, 3'b001, 0, 4'h6, 8'hFF, 0, 0, 0, 1);
    send(0, 8'hFF, 0, 2'b01, 3'b011, 0, 4'h7, 8'h00, 0, 0, 0, 1);

    // DYN resolved from frm, then an illegal frm
    frm_i = 3'b010;
    send(1, 8'h10, 1, 2'b01, 3'b111, 0, 4'h8, 8'h11, 1, 0, 0, 1);
    frm_i = 3'b110;
    send(1, 8'h10, 1, 2'b01, 3'b111, 0, 4'h9, 8'h10, 1, 0, 1, 1);
    frm_i = 3'b000;

    // Exact zero sign under effective subtraction
    send(2, 8'h00, 0, 2'b00, 3'b010, 1, 4'hA, 8'h00, 1, 1, 0, 1);
    send(2, 8'h00, 0, 2'b00, 3'b000, 1, 4'hB, 8'h00, 0, 1, 0, 1);

    // Fairness: pointer is 0 here, all three valid continuously
    out_ready_i = 1'b1;
    for (int r = 0; r < N; r++)
      set_req(r, 8'(8'h20 + r), 0, 2'b00, 3'b001, 0, 4'(8 + r));
    for (int k = 0; k < 6; k++) begin
      #1;
      check("fair_ready", 32'(in_ready_o), 32'(1 << (k % 3)));
      push(k % 3, 8'(8'h20 + k % 3), 0, 0, 0, 0, 4'(8 + k % 3));
      step();
    end
    in_valid_i = '0;
    step();

    // Backpressure: req0 fills output, req2 waits 4 cycles
    send(0, 8'h30, 0, 2'b00, 3'b001, 0, 4'h3, 8'h30, 0, 0, 0, 0);
    set_req(2, 8'h40, 0, 2'b00, 3'b001, 0, 4'h5);
    for (int k = 0; k < 4; k++) begin
      #1;
      check("bp_ready", 32'(in_ready_o), 0);
      check("bp_hold",  32'(out_abs_o), 32'h30);
      check("bp_valid", 32'(out_valid_o), 1);
      step();
    end
    out_ready_i = 1'b1;
    #1;
    check("bp_release", 32'(in_ready_o), 32'b100);
    push(2, 8'h40, 0, 0, 0, 0, 4'h5);
    step();
    in_valid_i = '0;
    set_req(0, 8'h50, 0, 2'b00, 3'b001, 0, 4'h1);
    set_req(1, 8'h51, 0, 2'b00, 3'b001, 0, 4'h2);
    #1;
    check("bp_ptr0", 32'(in_ready_o), 32'b001);
    push(0, 8'h50, 0, 0, 0, 0, 4'h1);
    step();
    in_valid_i = '0;
    step();

    // Flush: pending output killed, input blocked, pointer kept
    send(1, 8'h60, 0, 2'b00, 3'b001, 0, 4'h6, 8'h60, 0, 0, 0, 0);
    flush_i     = 1'b1;
    out_ready_i = 1'b1;
    set_req(0, 8'h61, 0, 2'b00, 3'b001, 0, 4'h7);
    #1;
    check("fl_ready", 32'(in_ready_o), 0);
    step();
    flush_i    = 1'b0;
    in_valid_i = '0;
    check("fl_valid", 32'(out_valid_o), 0);
    set_req(1, 8'h62, 0, 2'b00, 3'b001, 0, 4'h8);
    set_req(2, 8'h63, 0, 2'b00, 3'b001, 0, 4'h9);
    #1;
    check("fl_ptr", 32'(in_ready_o), 32'b100);
    push(2, 8'h63, 0, 0, 0, 0, 4'h9);
    step();
    in_valid_i = '0;
    step();

    // Reset while stalled
    send(0, 8'h55, 1, 2'b01, 3'b001, 0, 4'hA, 8'h55, 1, 0, 0, 0);
    set_req(1, 8'h70, 0, 2'b00, 3'b001, 0, 4'h1);
    step();
    #1;
    check("st_ready", 32'(in_ready_o), 0);
    step();
    in_valid_i = '0;
    rst_i      = 1'b1;
    step();
    check("mr_valid", 32'(out_valid_o), 0);
    check("mr_abs",   32'(out_abs_o), 0);
    check("mr_tag",   32'(out_tag_o), 0);
    check("mr_id",    32'(out_id_o), 0);
    check("mr_flags", 32'({out_sign_o, out_exact_zero_o,
                           out_inexact_o, out_illegal_rm_o}), 0);
    rst_i       = 1'b0;
    out_ready_i = 1'b1;
    set_req(0, 8'h71, 0, 2'b00, 3'b001, 0, 4'h2);
    set_req(2, 8'h72, 0, 2'b00, 3'b001, 0, 4'h3);
    #1;
    check("mr_ptr", 32'(in_ready_o), 32'b001);
    push(0, 8'h71, 0, 0, 0, 0, 4'h2);
    step();
    in_valid_i = '0;
    step();
    step();
    check("queue_empty", 32'(q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
